// File: rtl/sd_spi_card_resp.sv
// ---------------------------------------------------------------------------
// sd_spi_card_resp
//
// Behavioural SD card responder for the SPI-mode command layer. The host
// clocks 48-bit command frames in on MOSI. The block answers with
// NCR_BYTES filler bytes of 0xFF and then with an R1 or R7 response on MISO.
// It also models the init handshake CMD0 / CMD8 / CMD55 / ACMD41 so that a
// host driver can be brought up against it.
//
// All SPI inputs are oversampled by clk_sd, which must run at least 8x
// faster than SCLK. The SPI clock is never used as a clock here.
//
// Parameters
//   NCR_BYTES          number of 0xFF filler bytes before a response (1-8)
//   ACMD41_BUSY_COUNT  number of ACMD41s answered busy before ready
//
// Ports
//   clk_sd       in   system clock
//   reset_n      in   asynchronous active-low reset
//   sd_spi_clk   in   SPI clock from host (mode 0, idles low)
//   sd_spi_cs    in   chip select, active low
//   sd_spi_mosi  in   command data from host
//   sd_spi_miso  out  response data to host, idles high
//   cmd_valid    out  one-cycle pulse per accepted command frame
//   cmd_index    out  index of the last accepted command
//   cmd_arg      out  argument of the last accepted command
//   card_ready   out  high once initialisation has completed
//
// Build option
//   SD_RESP_CRC_CHECK_EN  when defined, the CRC7 of each frame is checked.
//                         A frame with a bad CRC is not executed and is
//                         answered with the CRC-error R1. When undefined, the
//                         CRC field is ignored and no CRC logic exists.
// ---------------------------------------------------------------------------
module sd_spi_card_resp #(
  parameter int NCR_BYTES         = 1,
  parameter int ACMD41_BUSY_COUNT = 2
) (
  input  logic        clk_sd,
  input  logic        reset_n,
  input  logic        sd_spi_clk,
  input  logic        sd_spi_cs,
  input  logic        sd_spi_mosi,
  output logic        sd_spi_miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  typedef enum logic [1:0] {
    HUNT,
    RX,
    NCR,
    TX
  } state_t;

  localparam int          NCR_BITS  = 8 * NCR_BYTES;
  localparam logic [6:0]  NCR_LAST  = 7'(NCR_BITS - 1);
  localparam logic [15:0] BUSY_INIT = 16'(ACMD41_BUSY_COUNT);

  // Synchronisers and edge detection
  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;
  logic       cs_s;
  logic       mosi_s;
  logic       sclk_rise;
  logic       sclk_fall;

  // FSM and datapath
  state_t      state;
  state_t      state_next;
  logic [5:0]  rx_cnt;
  logic [46:0] shift_reg;
  logic [47:0] frame_full;
  logic [6:0]  ncr_cnt;
  logic [5:0]  tx_cnt;
  logic [5:0]  resp_len;
  logic [39:0] resp_reg;
  logic        tx_last;

  // Card state
  logic        idle_flag;
  logic        app_flag;
  logic [15:0] busy_cnt;

  // FSM strobes
  logic frame_start;
  logic rx_shift;
  logic frame_ok;
  logic ncr_step;
  logic tx_step;

  // Command execution results
  logic [5:0]  f_index;
  logic [31:0] f_arg;
  logic        idle_n;
  logic        app_n;
  logic [15:0] busy_n;
  logic [7:0]  r1_n;
  logic [39:0] resp_n;
  logic [5:0]  len_n;

  // SCLK resets to 0 so that no edge appears when reset is released.
  // CS and MOSI reset to 1, which is their idle level.
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sd_spi_clk};
      cs_sync   <= {cs_sync[0], sd_spi_cs};
      mosi_sync <= {mosi_sync[0], sd_spi_mosi};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;

  // The frame as it will look once the current MOSI bit is shifted in.
  // On the 48th rising edge this is the complete frame. The start bit sits
  // in bit 47.
  assign frame_full = {shift_reg, mosi_s};
  assign f_index    = frame_full[45:40];
  assign f_arg      = frame_full[39:8];
  assign tx_last    = (tx_cnt == resp_len - 6'd1);

`ifdef SD_RESP_CRC_CHECK_EN
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  logic crc_bad;
  assign crc_bad = (crc7_calc(frame_full[47:8]) != frame_full[7:1]);

  logic unused_frame_bits;
  assign unused_frame_bits = frame_full[47];
`else
  logic unused_frame_bits;
  assign unused_frame_bits = ^{frame_full[47], frame_full[7:1]};
`endif

  // State register
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes. A high CS overrides everything:
  // any transfer in progress is abandoned and the FSM returns to HUNT.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    rx_shift    = 1'b0;
    frame_ok    = 1'b0;
    ncr_step    = 1'b0;
    tx_step     = 1'b0;
    if (cs_s) begin
      state_next = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (sclk_rise && !mosi_s) begin
            frame_start = 1'b1;
            state_next  = RX;
          end
        end
        RX: begin
          if (sclk_rise) begin
            rx_shift = 1'b1;
            if (rx_cnt == 6'd47) begin
              if (frame_full[46] && frame_full[0]) begin
                frame_ok   = 1'b1;
                state_next = NCR;
              end else begin
                state_next = HUNT;
              end
            end
          end
        end
        NCR: begin
          if (sclk_fall) begin
            ncr_step = 1'b1;
            if (ncr_cnt == NCR_LAST) begin
              state_next = TX;
            end
          end
        end
        TX: begin
          if (sclk_fall) begin
            tx_step = 1'b1;
            if (tx_last) begin
              state_next = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Command execution. This evaluates the completed frame against the
  // current card state. The results are committed only when frame_ok fires.
  // Any command except CMD55 leaves the app flag cleared.
  always_comb begin
    idle_n = idle_flag;
    app_n  = 1'b0;
    busy_n = busy_cnt;
    r1_n   = {7'b0, idle_flag};
    len_n  = 6'd8;
    case (f_index)
      6'd0: begin
        idle_n = 1'b1;
        busy_n = BUSY_INIT;
        r1_n   = 8'h01;
      end
      6'd8: begin
        len_n = 6'd40;
      end
      6'd55: begin
        app_n = 1'b1;
      end
      6'd41: begin
        if (app_flag) begin
          if (busy_cnt != 16'd0) begin
            busy_n = busy_cnt - 16'd1;
            r1_n   = 8'h01;
          end else begin
            idle_n = 1'b0;
            r1_n   = 8'h00;
          end
        end else begin
          r1_n = {5'b0, 1'b1, 1'b0, idle_flag};
        end
      end
      default: begin
        r1_n = {5'b0, 1'b1, 1'b0, idle_flag};
      end
    endcase
`ifdef SD_RESP_CRC_CHECK_EN
    // A corrupted frame must not change the card state.
    if (crc_bad) begin
      idle_n = idle_flag;
      app_n  = app_flag;
      busy_n = busy_cnt;
      r1_n   = {4'b0, 1'b1, 2'b0, idle_flag};
      len_n  = 6'd8;
    end
`endif
    // The response is left-aligned so that TX always shifts out bit 39.
    if (len_n == 6'd40) begin
      resp_n = {r1_n, 16'h0000, 4'h0, f_arg[11:8], f_arg[7:0]};
    end else begin
      resp_n = {r1_n, 32'hFFFF_FFFF};
    end
  end

  // Datapath, card state and outputs. MISO changes only on SCLK falling
  // edges, or at once when CS goes high. Outside TX it always drives 1.
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt      <= 6'd0;
      shift_reg   <= '0;
      ncr_cnt     <= 7'd0;
      tx_cnt      <= 6'd0;
      resp_len    <= 6'd8;
      resp_reg    <= '1;
      idle_flag   <= 1'b1;
      app_flag    <= 1'b0;
      busy_cnt    <= BUSY_INIT;
      cmd_valid   <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
      sd_spi_miso <= 1'b1;
    end else begin
      cmd_valid <= 1'b0;
      if (frame_start) begin
        rx_cnt    <= 6'd1;
        shift_reg <= '0;
      end
      if (rx_shift) begin
        shift_reg <= frame_full[46:0];
        rx_cnt    <= rx_cnt + 6'd1;
      end
      if (frame_ok) begin
        cmd_valid <= 1'b1;
        cmd_index <= f_index;
        cmd_arg   <= f_arg;
        idle_flag <= idle_n;
        app_flag  <= app_n;
        busy_cnt  <= busy_n;
        resp_reg  <= resp_n;
        resp_len  <= len_n;
        ncr_cnt   <= 7'd0;
        tx_cnt    <= 6'd0;
      end
      if (ncr_step) begin
        ncr_cnt <= ncr_cnt + 7'd1;
      end
      if (tx_step) begin
        resp_reg <= {resp_reg[38:0], 1'b1};
        tx_cnt   <= tx_cnt + 6'd1;
      end
      if (cs_s) begin
        sd_spi_miso <= 1'b1;
      end else if (sclk_fall) begin
        sd_spi_miso <= (state == TX) ? resp_reg[39] : 1'b1;
      end
    end
  end

  assign card_ready = ~idle_flag;

endmodule

// File: tb/tb_sd_spi_card_resp.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_card_resp
//
// Bench for the SPI-mode SD card responder. The bench acts as an SPI mode 0
// host. A second instance with NCR_BYTES=3 shares SCLK and MOSI but has its
// own chip select. Expected responses come from a small card-state model
// (idle/app flags, busy counter) or from fixed reference frames.
// ---------------------------------------------------------------------------
module tb_sd_spi_card_resp;

  localparam int BUSY = 2;
  localparam int HALF = 40;

  logic        clk_sd;
  logic        reset_n;
  logic        sclk;
  logic        cs;
  logic        cs3;
  logic        mosi;
  logic        miso;
  logic        miso3;
  logic        cmd_valid;
  logic        cmd_valid3;
  logic [5:0]  cmd_index;
  logic [5:0]  cmd_index3;
  logic [31:0] cmd_arg;
  logic [31:0] cmd_arg3;
  logic        card_ready;
  logic        card_ready3;

  int checks = 0;
  int passes = 0;
  int valid_cnt = 0;
  int valid3_cnt = 0;

  bit         m_idle;
  bit         m_app;
  int         m_busy;
  bit         exp_valid;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  sd_spi_card_resp #(.NCR_BYTES(1), .ACMD41_BUSY_COUNT(BUSY)) dut (
    .clk_sd(clk_sd), .reset_n(reset_n), .sd_spi_clk(sclk), .sd_spi_cs(cs),
    .sd_spi_mosi(mosi), .sd_spi_miso(miso), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .card_ready(card_ready)
  );

  sd_spi_card_resp #(.NCR_BYTES(3), .ACMD41_BUSY_COUNT(BUSY)) dut3 (
    .clk_sd(clk_sd), .reset_n(reset_n), .sd_spi_clk(sclk), .sd_spi_cs(cs3),
    .sd_spi_mosi(mosi), .sd_spi_miso(miso3), .cmd_valid(cmd_valid3),
    .cmd_index(cmd_index3), .cmd_arg(cmd_arg3), .card_ready(card_ready3)
  );

  initial begin
    clk_sd = 1'b0;
    forever #5 clk_sd = ~clk_sd;
  end

  always @(negedge clk_sd) begin
    if (cmd_valid === 1'b1) valid_cnt++;
    if (cmd_valid3 === 1'b1) valid3_cnt++;
  end

  // CRC7 computed as the remainder of polynomial division by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7(body), 1'b1};
  endfunction

  // Card model: produces the expected response bytes for one frame
  task automatic model_cmd(input logic [47:0] f);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  idle8;
    exp_q.delete();
    exp_valid = (f[46] === 1'b1) && (f[0] === 1'b1);
    if (!exp_valid) return;
    idx   = f[45:40];
    arg   = f[39:8];
    idle8 = {7'b0, m_idle};
`ifdef SD_RESP_CRC_CHECK_EN
    if (crc7(f[47:8]) != f[7:1]) begin
      exp_q.push_back(8'h08 | idle8);
      return;
    end
`endif
    if (idx == 6'd0) begin
      m_idle = 1'b1; m_app = 1'b0; m_busy = BUSY;
      exp_q.push_back(8'h01);
    end else if (idx == 6'd8) begin
      m_app = 1'b0;
      exp_q.push_back(idle8);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back({4'h0, arg[11:8]});
      exp_q.push_back(arg[7:0]);
    end else if (idx == 6'd55) begin
      m_app = 1'b1;
      exp_q.push_back(idle8);
    end else if (idx == 6'd41 && m_app) begin
      m_app = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        exp_q.push_back(8'h01);
      end else begin
        m_idle = 1'b0;
        exp_q.push_back(8'h00);
      end
    end else begin
      m_app = 1'b0;
      exp_q.push_back(8'h04 | idle8);
    end
  endtask

  // Host side: one mode-0 bit, MISO sampled on the rising edge
  task automatic spi_bit(input logic b, input bit sel3, output logic r);
    mosi = b;
    #HALF;
    sclk = 1'b1;
    r = sel3 ? miso3 : miso;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit sel3, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], sel3, r);
      rx[i] = r;
    end
  endtask

  task automatic send_frame(input logic [47:0] f, input bit sel3);
    logic [7:0] dummy;
    for (int k = 5; k >= 0; k--) spi_byte(f[k*8 +: 8], sel3, dummy);
    if (!sel3) model_cmd(f);
  endtask

  task automatic read_bytes(input int n, input bit sel3);
    logic [7:0] rx;
    got_q.delete();
    for (int k = 0; k < n; k++) begin
      spi_byte(8'hFF, sel3, rx);
      got_q.push_back(rx);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; cs = 1'b1; cs3 = 1'b1; sclk = 1'b0; mosi = 1'b1;
    #2 reset_n = 1'b0;
    #21;
    checks++; if (miso !== 1'b1) $display("[TB] FAIL reset_miso_held: got %b expected 1", miso); else passes++;
    checks++; if (card_ready !== 1'b0) $display("[TB] FAIL reset_ready_held: got %b expected 0", card_ready); else passes++;
    #20 reset_n = 1'b1;
    m_idle = 1'b1; m_app = 1'b0; m_busy = BUSY;
    repeat (3) @(negedge clk_sd);
    checks++; if (miso !== 1'b1) $display("[TB] FAIL reset_miso: got %b expected 1", miso); else passes++;
    checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); else passes++;
    checks++; if (cmd_index !== 6'd0) $display("[TB] FAIL reset_cmd_index: got %0d expected 0", cmd_index); else passes++;
    checks++; if (cmd_arg !== 32'd0) $display("[TB] FAIL reset_cmd_arg: got %h expected 0", cmd_arg); else passes++;
    checks++; if (card_ready !== 1'b0) $display("[TB] FAIL reset_card_ready: got %b expected 0", card_ready); else passes++;
  endtask

  task automatic test_cmd0();
    int v0;
    cs = 1'b0;
    repeat (4) @(negedge clk_sd);
    v0 = valid_cnt;
    send_frame(48'h40_0000_0000_95, 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (got_q[0] !== 8'hFF) $display("[TB] FAIL cmd0_ncr: got %h expected ff", got_q[0]); else passes++;
    checks++; if (got_q[1] !== 8'h01) $display("[TB] FAIL cmd0_r1: got %h expected 01", got_q[1]); else passes++;
    checks++; if (got_q[2] !== 8'hFF) $display("[TB] FAIL cmd0_tail: got %h expected ff", got_q[2]); else passes++;
    checks++; if (valid_cnt - v0 !== 1) $display("[TB] FAIL cmd0_valid_pulses: got %0d expected 1", valid_cnt - v0); else passes++;
    checks++; if (cmd_index !== 6'd0) $display("[TB] FAIL cmd0_index: got %0d expected 0", cmd_index); else passes++;
  endtask

  task automatic test_cmd8();
    logic [7:0] ref7 [7];
    ref7 = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hFF};
    send_frame(48'h48_0000_01AA_87, 1'b0);
    read_bytes(7, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got_q[k] !== ref7[k]) $display("[TB] FAIL cmd8_byte%0d: got %h expected %h", k, got_q[k], ref7[k]);
      else passes++;
    end
    checks++; if (cmd_index !== 6'd8) $display("[TB] FAIL cmd8_index: got %0d expected 8", cmd_index); else passes++;
    checks++; if (cmd_arg !== 32'h0000_01AA) $display("[TB] FAIL cmd8_arg: got %h expected 000001aa", cmd_arg); else passes++;
  endtask

  task automatic test_acmd41_init();
    logic [7:0] ref_r1 [3];
    logic       ref_rdy [3];
    ref_r1  = '{8'h01, 8'h01, 8'h00};
    ref_rdy = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send_frame(48'h77_0000_0000_65, 1'b0);
      read_bytes(3, 1'b0);
      checks++; if (got_q[1] !== 8'h01) $display("[TB] FAIL cmd55_r1_%0d: got %h expected 01", i, got_q[1]); else passes++;
      send_frame(48'h69_4000_0000_77, 1'b0);
      read_bytes(3, 1'b0);
      checks++; if (got_q[1] !== ref_r1[i]) $display("[TB] FAIL acmd41_r1_%0d: got %h expected %h", i, got_q[1], ref_r1[i]); else passes++;
      checks++; if (card_ready !== ref_rdy[i]) $display("[TB] FAIL acmd41_ready_%0d: got %b expected %b", i, card_ready, ref_rdy[i]); else passes++;
    end
    send_frame(48'h77_0000_0000_65, 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (got_q[1] !== 8'h00) $display("[TB] FAIL cmd55_ready_r1: got %h expected 00", got_q[1]); else passes++;
  endtask

  task automatic test_illegal_abort();
    logic r;
    send_frame(48'h40_0000_0000_95, 1'b0);
    read_bytes(3, 1'b0);
    send_frame(make_frame(6'd17, 32'h0000_1000), 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (got_q[1] !== 8'h05) $display("[TB] FAIL cmd17_r1: got %h expected 05", got_q[1]); else passes++;
    checks++; if (cmd_index !== 6'd17) $display("[TB] FAIL cmd17_index: got %0d expected 17", cmd_index); else passes++;
    // Second CMD17, cut off by CS after a few response bits
    send_frame(make_frame(6'd17, $urandom), 1'b0);
    read_bytes(1, 1'b0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, r);
    #HALF;
    checks++; if (miso !== 1'b0) $display("[TB] FAIL abort_pre_miso: got %b expected 0", miso); else passes++;
    cs = 1'b1;
    #HALF;
    checks++; if (miso !== 1'b1) $display("[TB] FAIL abort_miso: got %b expected 1", miso); else passes++;
    cs = 1'b0;
    repeat (4) @(negedge clk_sd);
    send_frame(48'h40_0000_0000_95, 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (got_q[1] !== 8'h01) $display("[TB] FAIL abort_cmd0_r1: got %h expected 01", got_q[1]); else passes++;
  endtask

  task automatic test_crc();
    logic [7:0] idle_bad;
    logic [7:0] ready_bad;
    logic       ready_after;
    int         v0;
`ifdef SD_RESP_CRC_CHECK_EN
    idle_bad = 8'h09; ready_bad = 8'h08; ready_after = 1'b1;
`else
    idle_bad = 8'h01; ready_bad = 8'h01; ready_after = 1'b0;
`endif
    v0 = valid_cnt;
    send_frame(48'h40_0000_0000_97, 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (got_q[1] !== idle_bad) $display("[TB] FAIL crc_idle_r1: got %h expected %h", got_q[1], idle_bad); else passes++;
    checks++; if (valid_cnt - v0 !== 1) $display("[TB] FAIL crc_valid_pulses: got %0d expected 1", valid_cnt - v0); else passes++;
    checks++; if (card_ready !== 1'b0) $display("[TB] FAIL crc_idle_ready: got %b expected 0", card_ready); else passes++;
    for (int i = 0; i < 3; i++) begin
      send_frame(48'h77_0000_0000_65, 1'b0);
      read_bytes(3, 1'b0);
      send_frame(48'h69_4000_0000_77, 1'b0);
      read_bytes(3, 1'b0);
    end
    checks++; if (card_ready !== 1'b1) $display("[TB] FAIL crc_init_ready: got %b expected 1", card_ready); else passes++;
    send_frame(48'h40_0000_0000_97, 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (got_q[1] !== ready_bad) $display("[TB] FAIL crc_ready_r1: got %h expected %h", got_q[1], ready_bad); else passes++;
    checks++; if (card_ready !== ready_after) $display("[TB] FAIL crc_ready_kept: got %b expected %b", card_ready, ready_after); else passes++;
    send_frame(48'h40_0000_0000_95, 1'b0);
    read_bytes(3, 1'b0);
    checks++; if (card_ready !== 1'b0) $display("[TB] FAIL crc_restore_idle: got %b expected 0", card_ready); else passes++;
  endtask

  task automatic test_ncr3();
    logic [31:0] bits;
    logic        r;
    int          ones;
    bit          seen0;
    int          v0;
    cs = 1'b1; cs3 = 1'b0;
    repeat (4) @(negedge clk_sd);
    v0 = valid3_cnt;
    send_frame(48'h40_0000_0000_95, 1'b1);
    for (int i = 31; i >= 0; i--) begin
      spi_bit(1'b1, 1'b1, r);
      bits[i] = r;
    end
    ones = 0; seen0 = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (bits[i] === 1'b0) seen0 = 1'b1;
      else if (!seen0) ones++;
    end
    checks++; if (ones !== 24) $display("[TB] FAIL ncr3_high_bits: got %0d expected 24", ones); else passes++;
    checks++; if (bits[7:0] !== 8'h01) $display("[TB] FAIL ncr3_r1: got %h expected 01", bits[7:0]); else passes++;
    read_bytes(1, 1'b1);
    checks++; if (got_q[0] !== 8'hFF) $display("[TB] FAIL ncr3_tail: got %h expected ff", got_q[0]); else passes++;
    checks++; if (valid3_cnt - v0 !== 1) $display("[TB] FAIL ncr3_valid: got %0d expected 1", valid3_cnt - v0); else passes++;
    checks++; if (cmd_index3 !== 6'd0 || cmd_arg3 !== 32'd0 || card_ready3 !== 1'b0)
      $display("[TB] FAIL ncr3_outputs: got idx %0d arg %h ready %b expected 0 0 0", cmd_index3, cmd_arg3, card_ready3);
    else passes++;
    cs3 = 1'b1;
    repeat (4) @(negedge clk_sd);
  endtask

  task automatic test_random();
    logic [47:0] f;
    logic [5:0]  idx;
    logic [7:0]  want;
    int          kind;
    int          v0;
    int          n;
    cs = 1'b0;
    repeat (4) @(negedge clk_sd);
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0:       idx = 6'd0;
        1, 2:    idx = 6'd8;
        3, 4:    idx = 6'd55;
        5, 6:    idx = 6'd41;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      f = make_frame(idx, $urandom);
      if (kind == 8) begin
        if ($urandom_range(0, 1) == 1) f[46] = 1'b0;
        else f[0] = 1'b0;
      end
      if (kind == 9) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
      v0 = valid_cnt;
      send_frame(f, 1'b0);
      n = exp_q.size() + 2;
      read_bytes(n, 1'b0);
      for (int k = 0; k < n; k++) begin
        want = (k == 0 || k == n - 1) ? 8'hFF : exp_q[k-1];
        checks++;
        if (got_q[k] !== want) $display("[TB] FAIL rand%0d_byte%0d (frame %h): got %h expected %h", it, k, f, got_q[k], want);
        else passes++;
      end
      checks++;
      if (valid_cnt - v0 !== int'(exp_valid)) $display("[TB] FAIL rand%0d_valid: got %0d expected %0d", it, valid_cnt - v0, exp_valid);
      else passes++;
      if (exp_valid) begin
        checks++;
        if (cmd_index !== f[45:40] || cmd_arg !== f[39:8])
          $display("[TB] FAIL rand%0d_cmd: got %0d/%h expected %0d/%h", it, cmd_index, cmd_arg, f[45:40], f[39:8]);
        else passes++;
      end
      checks++;
      if (card_ready !== !m_idle) $display("[TB] FAIL rand%0d_ready: got %b expected %b", it, card_ready, !m_idle);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_acmd41_init();
    test_illegal_abort();
    test_crc();
    test_ncr3();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
